// File: rtl/adder_tx_pkg.sv
// Shared types and constants for the adder result serial link.
package adder_tx_pkg;
  localparam int RESULT_W = 9;
  localparam int DEFAULT_CLKS_PER_BIT = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;
endpackage

// File: rtl/tx_baud_counter.sv
// Bit-time counter: runs 0..CLKS_PER_BIT-1 while enabled, ticks on the last count.
module tx_baud_counter #(
  parameter int CLKS_PER_BIT = adder_tx_pkg::DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  logic [7:0] cnt;

  assign tick = en && (cnt == 8'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (!en || tick)  cnt <= '0;
    else                   cnt <= cnt + 8'd1;
  end
endmodule

// File: rtl/adder_result_serial_tx.sv
// Bit-serial transmitter for the 9-bit adder result: start, data LSB first,
// optional even parity, stop. Line idles high.
module adder_result_serial_tx
  import adder_tx_pkg::*;
#(
  parameter int DATA_W       = RESULT_W,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_cnt
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  tx_state_t         state;
  logic [DATA_W-1:0] sr;
  logic              par;
  logic [CNT_W-1:0]  bit_cnt;
  logic              tick;

  tx_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .tick (tick)
  );

  // done decodes registered state only, so it is still free of input paths.
  assign done = (state == STOP) && tick;

  // tx is loaded with the value of the bit being entered, so it changes on the
  // same edge as the state and needs no output decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      frame_cnt <= '0;
      sr        <= '0;
      par       <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          sr      <= data_in;
          par     <= ^data_in;
          bit_cnt <= '0;
          busy    <= 1'b1;
          tx      <= 1'b0;
          state   <= START;
        end
        START: if (tick) begin
          tx    <= sr[0];
          state <= DATA;
        end
        DATA: if (tick) begin
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            if (PARITY_EN != 0) begin
              tx    <= par;
              state <= PARITY;
            end else begin
              tx    <= 1'b1;
              state <= STOP;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            sr      <= {1'b0, sr[DATA_W-1:1]};
            tx      <= sr[1];
          end
        end
        PARITY: if (tick) begin
          tx    <= 1'b1;
          state <= STOP;
        end
        STOP: if (tick) begin
          busy      <= 1'b0;
          frame_cnt <= frame_cnt + 8'd1;
          state     <= IDLE;
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adder_result_serial_tx.sv
// Bench for adder_result_serial_tx: three instances (default, no parity, one clk per bit).
module tb_adder_result_serial_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] load = '0;
  logic [8:0] data_in = '0;
  logic       tx_v [3];
  logic       busy_v [3];
  logic       done_v [3];
  logic [7:0] fcnt_v [3];

  int tests = 0;
  int fails = 0;
  int exp_cnt [3] = '{0, 0, 0};

  bit etx [$];
  bit otx [$];
  bit obusy [$];
  bit odone [$];

  always #5 clk = ~clk;

  adder_result_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut0 (
    .clk(clk), .rst(rst), .load(load[0]), .data_in(data_in),
    .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]), .frame_cnt(fcnt_v[0]));
  adder_result_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) dut1 (
    .clk(clk), .rst(rst), .load(load[1]), .data_in(data_in),
    .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]), .frame_cnt(fcnt_v[1]));
  adder_result_serial_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1)) dut2 (
    .clk(clk), .rst(rst), .load(load[2]), .data_in(data_in),
    .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]), .frame_cnt(fcnt_v[2]));

  // Reference line waveform: start, data LSB first, even parity, stop; each bit cpb cycles.
  task automatic expect_frame(input logic [8:0] data, input int cpb, input bit pe);
    bit bits [$];
    etx.delete();
    bits.push_back(1'b0);
    for (int i = 0; i < 9; i++) bits.push_back(data[i]);
    if (pe) bits.push_back(bit'($countones(data) % 2));
    bits.push_back(1'b1);
    foreach (bits[b]) for (int c = 0; c < cpb; c++) etx.push_back(bits[b]);
  endtask

  // Loads a frame and records one sample per cycle; optionally fires ignored loads.
  task automatic capture(input int d, input logic [8:0] data, input int ncyc, input bit inj);
    otx.delete(); obusy.delete(); odone.delete();
    @(negedge clk);
    load[d] = 1'b1; data_in = data;
    @(negedge clk);
    load[d] = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      otx.push_back(tx_v[d]); obusy.push_back(busy_v[d]); odone.push_back(done_v[d]);
      if (inj && (k == 10 || k == ncyc)) begin
        load[d] = 1'b1; data_in = 9'h100;
      end else begin
        load[d] = 1'b0; data_in = 9'($urandom);
      end
      @(negedge clk);
    end
    load[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        tests++;
        if (tx_v[d] !== 1'b1 || busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || fcnt_v[d] !== 8'd0) begin
          fails++;
          $display("FAIL reset_idle dut%0d cyc%0d: tx=%b busy=%b done=%b cnt=%0d, want 1 0 0 0",
                   d, c, tx_v[d], busy_v[d], done_v[d], fcnt_v[d]);
        end
      end
    end
  endtask

  task automatic test_basic();
    logic [8:0] data;
    for (int n = 0; n < 4; n++) begin
      data = (n == 0) ? 9'h0A5 : 9'($urandom);
      expect_frame(data, 4, 1'b1);
      capture(0, data, etx.size(), 1'b0);
      exp_cnt[0]++;
      for (int i = 0; i < etx.size(); i++) begin
        tests++;
        if (otx[i] !== etx[i] || obusy[i] !== 1'b1 || odone[i] !== (i == etx.size() - 1)) begin
          fails++;
          $display("FAIL basic_frame %h cyc%0d: tx=%b busy=%b done=%b, want tx=%b busy=1 done=%b",
                   data, i + 1, otx[i], obusy[i], odone[i], etx[i], i == etx.size() - 1);
        end
      end
      tests++;
      if (busy_v[0] !== 1'b0 || tx_v[0] !== 1'b1 || fcnt_v[0] !== 8'(exp_cnt[0])) begin
        fails++;
        $display("FAIL basic_end: busy=%b tx=%b cnt=%0d, want 0 1 %0d",
                 busy_v[0], tx_v[0], fcnt_v[0], exp_cnt[0]);
      end
    end
  endtask

  task automatic test_carry_parity();
    logic [8:0] data;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 3; n++) begin
        data = (n == 0) ? 9'h1FF : 9'($urandom);
        expect_frame(data, 4, d == 0);
        capture(d, data, etx.size(), 1'b0);
        exp_cnt[d]++;
        for (int i = 0; i < etx.size(); i++) begin
          tests++;
          if (otx[i] !== etx[i] || odone[i] !== (i == etx.size() - 1)) begin
            fails++;
            $display("FAIL carry_parity dut%0d %h cyc%0d: tx=%b done=%b, want tx=%b done=%b",
                     d, data, i + 1, otx[i], odone[i], etx[i], i == etx.size() - 1);
          end
        end
        tests++;
        if (busy_v[d] !== 1'b0 || fcnt_v[d] !== 8'(exp_cnt[d])) begin
          fails++;
          $display("FAIL carry_parity_end dut%0d: busy=%b cnt=%0d, want 0 %0d",
                   d, busy_v[d], fcnt_v[d], exp_cnt[d]);
        end
      end
    end
  endtask

  task automatic test_ignored_load();
    expect_frame(9'h003, 4, 1'b1);
    capture(0, 9'h003, etx.size(), 1'b1);
    exp_cnt[0]++;
    for (int i = 0; i < etx.size(); i++) begin
      tests++;
      if (otx[i] !== etx[i] || obusy[i] !== 1'b1 || odone[i] !== (i == etx.size() - 1)) begin
        fails++;
        $display("FAIL ignored_load cyc%0d: tx=%b busy=%b done=%b, want tx=%b busy=1 done=%b",
                 i + 1, otx[i], obusy[i], odone[i], etx[i], i == etx.size() - 1);
      end
    end
    for (int c = 0; c < 2; c++) begin
      tests++;
      if (busy_v[0] !== 1'b0 || tx_v[0] !== 1'b1 || fcnt_v[0] !== 8'(exp_cnt[0])) begin
        fails++;
        $display("FAIL ignored_load_after cyc%0d: busy=%b tx=%b cnt=%0d, want 0 1 %0d",
                 c, busy_v[0], tx_v[0], fcnt_v[0], exp_cnt[0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    load[0] = 1'b1; data_in = 9'h0A5;
    @(negedge clk);
    load[0] = 1'b0;
    repeat (21) @(negedge clk);
    tests++;
    if (busy_v[0] !== 1'b1 || tx_v[0] !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_pre: busy=%b tx=%b, want 1 0 (data bit 4)", busy_v[0], tx_v[0]);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || fcnt_v[0] !== 8'd0) begin
      fails++;
      $display("FAIL mid_reset_async: tx=%b busy=%b done=%b cnt=%0d, want 1 0 0 0",
               tx_v[0], busy_v[0], done_v[0], fcnt_v[0]);
    end
    exp_cnt = '{0, 0, 0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_no_resume: tx=%b busy=%b, want 1 0", tx_v[0], busy_v[0]);
    end
    expect_frame(9'h055, 4, 1'b1);
    capture(0, 9'h055, etx.size(), 1'b0);
    exp_cnt[0]++;
    for (int i = 0; i < etx.size(); i++) begin
      tests++;
      if (otx[i] !== etx[i] || odone[i] !== (i == etx.size() - 1)) begin
        fails++;
        $display("FAIL mid_reset_frame cyc%0d: tx=%b done=%b, want tx=%b done=%b",
                 i + 1, otx[i], odone[i], etx[i], i == etx.size() - 1);
      end
    end
    tests++;
    if (fcnt_v[0] !== 8'd1) begin
      fails++;
      $display("FAIL mid_reset_cnt: cnt=%0d, want 1", fcnt_v[0]);
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [8:0] data;
    for (int n = 1; n <= 256; n++) begin
      data = 9'($urandom);
      expect_frame(data, 1, 1'b1);
      capture(2, data, etx.size(), 1'b0);
      exp_cnt[2] = (exp_cnt[2] + 1) % 256;
      for (int i = 0; i < etx.size(); i++) begin
        tests++;
        if (otx[i] !== etx[i] || obusy[i] !== 1'b1 || odone[i] !== (i == etx.size() - 1)) begin
          fails++;
          $display("FAIL wrap_frame%0d cyc%0d: tx=%b busy=%b done=%b, want tx=%b busy=1 done=%b",
                   n, i + 1, otx[i], obusy[i], odone[i], etx[i], i == etx.size() - 1);
        end
      end
      tests++;
      if (fcnt_v[2] !== 8'(exp_cnt[2])) begin
        fails++;
        $display("FAIL wrap_cnt frame%0d: cnt=%0d, want %0d", n, fcnt_v[2], exp_cnt[2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_parity();
    test_ignored_load();
    test_mid_reset();
    test_back_to_back_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/adder_result_serial_tx.md
Name: adder_result_serial_tx

Overview:
- Bit-serial transmitter that sends the 9-bit adder result (8-bit sum plus carry) off-chip on one output pin.
- Gives the test environment the opposite end of the pin interface: the adder drives data out on a single wire, and the bench acts as the receiver.
- Sits between the adder core and uo_out[0] inside the top module. Handshake with the core is load/busy.

Parameters:
- DATA_W, 9, payload bits per frame (sum[7:0] plus carry in the MSB).
- CLKS_PER_BIT, 4, clk cycles per serial bit; legal range 1-255.
- PARITY_EN, 1, 1 inserts an even-parity bit after the data; 0 omits it.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  one-cycle request to send data_in; accepted only while busy=0.
- data_in  input  DATA_W  payload, sampled on an accepted load.
- tx  output  1  serial line, idles high.
- busy  output  1  high from the cycle after an accepted load until the frame ends.
- done  output  1  one-cycle pulse in the final cycle of the stop bit.
- frame_cnt  output  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- Reset (asynchronous, any time, including mid-frame) forces:
  - state = IDLE, tx = 1, busy = 0, done = 0, frame_cnt = 0.
  - Shift register, bit counter and baud counter all cleared.
  - No partial frame resumes after reset is released.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx = 1.
  - load = 1 latches data_in into the shift register, computes parity = XOR of data_in, clears counters, and moves to START on the next edge.
  - busy rises on that same edge.
- Baud counter:
  - Counts 0 .. CLKS_PER_BIT-1 in every non-IDLE state.
  - A state advances only when the counter reaches CLKS_PER_BIT-1, so each bit holds exactly CLKS_PER_BIT cycles.
- START: tx = 0 for one bit time, then DATA.
- DATA:
  - tx = shift register LSB. Data is sent LSB first: sum[0] .. sum[7], then carry.
  - The register shifts right at each bit boundary.
  - The bit counter runs 0 .. DATA_W-1; after the last bit, go to PARITY if PARITY_EN = 1, else STOP.
- PARITY: tx = even-parity bit, so the number of 1s in data plus parity is even. Lasts one bit time, then STOP.
- STOP:
  - tx = 1 for one bit time.
  - done = 1 in the final cycle of STOP.
  - On the next edge: busy = 0, state = IDLE, frame_cnt increments.
- Frame length is 1 + DATA_W + PARITY_EN + 1 bits. Defaults: 12 bits, 48 clk cycles from the first START cycle to the end of STOP.
- Latency: tx first goes low in the cycle after the load edge.
- load while busy = 1 is ignored (no queueing); data_in changes have no effect on a frame in progress.
- load asserted in the same cycle done = 1 is also ignored. Back-to-back frames therefore have at least one IDLE cycle between them.
- CLKS_PER_BIT = 1: every state lasts exactly one cycle, and the same rules apply.
- Outputs are registered; tx has no combinational path from inputs.

Decomposition:
- Shared package adder_tx_pkg holds:
  - state enum tx_state_t (IDLE/START/DATA/PARITY/STOP);
  - localparam RESULT_W = 9;
  - the default CLKS_PER_BIT.
- One natural sub-module: tx_baud_counter (counter + tick output), reused later by a matching receiver.
- Parity, the shift register and the FSM stay in the top-level block.

Test Plan:
- Reset then idle: hold rst for 3 cycles, release, wait 20 cycles -> tx = 1, busy = 0, done = 0, frame_cnt = 0 throughout.
- Basic frame: data_in = 9'h0A5 with defaults -> tx shows 0, then 1,0,1,0,0,1,0,1,0 (LSB first), parity 0, stop 1. Each bit is 4 cycles, done pulses once at cycle 48, frame_cnt = 1.
- Carry/parity: data_in = 9'h1FF -> data bits are all 1 (nine 1s), so parity bit = 1. With PARITY_EN = 0 the frame is 11 bits / 44 cycles, with no parity slot.
- Ignored load: load 9'h003, then pulse load with 9'h100 at cycle 10 and in the done cycle -> only 9'h003 is transmitted, busy is never extended, frame_cnt = 1.
- Mid-frame reset: assert rst during DATA bit 4 -> tx = 1 and busy = 0 within the same cycle (asynchronous). After release, a new load of 9'h055 sends a clean full frame.
- Counter wrap: 256 back-to-back frames with CLKS_PER_BIT = 1 -> frame_cnt reads 255 after frame 255 and 0 after frame 256.
